// File: rtl/vga_sync_if.sv
// Video timing bundle between vga_sync (master) and the pixel generator / connector (slave).
interface vga_sync_if #(
  parameter int SCREEN_WIDTH = 10
);
  logic                    p_tick;
  logic                    hsync;
  logic                    vsync;
  logic                    video_on;
  logic                    frame_start;
  logic [SCREEN_WIDTH-1:0] x;
  logic [SCREEN_WIDTH-1:0] y;

  modport master (
    output p_tick, hsync, vsync, video_on, frame_start, x, y
  );

  modport slave (
    input  p_tick, hsync, vsync, video_on, frame_start, x, y
  );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v counters and sync/visible decode.
// Define VGA_SYNC_REG_OUT_EN to register x/y/hsync/vsync/video_on (one pixel of lag).
module vga_sync #(
  parameter int SCREEN_WIDTH = 10,
  parameter int PIXEL_DIV    = 4,
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(PIXEL_DIV - 1);
  localparam logic [SCREEN_WIDTH-1:0] H_LAST   = SCREEN_WIDTH'(H_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] V_LAST   = SCREEN_WIDTH'(V_TOTAL - 1);
  localparam logic [SCREEN_WIDTH-1:0] H_VIS    = SCREEN_WIDTH'(H_DISPLAY);
  localparam logic [SCREEN_WIDTH-1:0] V_VIS    = SCREEN_WIDTH'(V_DISPLAY);
  localparam logic [SCREEN_WIDTH-1:0] HS_FIRST = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] HS_LAST  = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [SCREEN_WIDTH-1:0] VS_FIRST = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [SCREEN_WIDTH-1:0] VS_LAST  = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [SCREEN_WIDTH-1:0] h_cnt;
  logic [SCREEN_WIDTH-1:0] v_cnt;
  logic                    tick;
  logic                    h_last;
  logic                    v_last;
  logic                    vis;
  logic                    hs_n;
  logic                    vs_n;

  assign tick   = (div_cnt == DIV_LAST);
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Decode looks only at h_cnt/v_cnt, so syncs cannot glitch between ticks.
  assign vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_n = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vs_n = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

  assign vga.p_tick      = tick;
  assign vga.frame_start = tick && h_last && v_last;

`ifdef VGA_SYNC_REG_OUT_EN
  logic [SCREEN_WIDTH-1:0] x_q;
  logic [SCREEN_WIDTH-1:0] y_q;
  logic                    hsync_q;
  logic                    vsync_q;
  logic                    video_on_q;

  // Loaded on the tick that advances the counters, so these trail them by one pixel.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else if (tick) begin
      x_q        <= h_cnt;
      y_q        <= v_cnt;
      hsync_q    <= hs_n;
      vsync_q    <= vs_n;
      video_on_q <= vis;
    end
  end

  assign vga.x        = x_q;
  assign vga.y        = y_q;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_on_q;
`else
  assign vga.x        = h_cnt;
  assign vga.y        = v_cnt;
  assign vga.hsync    = hs_n;
  assign vga.vsync    = vs_n;
  assign vga.video_on = vis;
`endif

endmodule
